// File: rtl/reg_wb_pkg.sv
// Shared types and default widths for the register write-back queue.
package reg_wb_pkg;

  localparam int WB_W = 8;
  localparam int WB_D = 3;

  typedef struct packed {
    logic [WB_D-1:0] addr;
    logic [WB_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/reg_wb_fifo.sv
// In-order write-back entry storage: circular buffer with pointers, occupancy
// and a per-slot live vector for pending/forwarding lookups.
module reg_wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output wb_entry_t        slots [DEPTH],
  output logic [DEPTH-1:0] live,
  output logic [AW-1:0]    rd_ptr,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  wb_entry_t        mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [DEPTH-1:0] live_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage write, pointer advance and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_entry;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the count
  always_comb begin
    live_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      live_s[i] = ({1'b0, AW'(AW'(i) - rd_ptr_r)} < count_r);
    end
  end

  assign live   = live_s;
  assign head   = mem_r[rd_ptr_r];
  assign slots  = mem_r;
  assign rd_ptr = rd_ptr_r;
  assign count  = count_r;

endmodule

// File: rtl/reg_wb_queue.sv
// Two-source round-robin write-back queue feeding the register file write port.
// Optional read-path forwarding of queued data is enabled by REG_WB_FORWARD_EN.
module reg_wb_queue
  import reg_wb_pkg::*;
#(
  parameter int W     = WB_W,
  parameter int D     = WB_D,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [D-1:0]  a_addr,
  input  logic [W-1:0]  a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [D-1:0]  b_addr,
  input  logic [W-1:0]  b_data,
  input  logic          wr_stall,
  output logic          wr_en,
  output logic [D-1:0]  wr_addr,
  output logic [W-1:0]  wr_data,
  output logic [2**D-1:0] pending,
  input  logic [D-1:0]  rd_addrA,
  input  logic [D-1:0]  rd_addrB,
  input  logic [W-1:0]  rf_dataA,
  input  logic [W-1:0]  rf_dataB,
  output logic [W-1:0]  fwd_dataA,
  output logic [W-1:0]  fwd_dataB
);

  localparam int AW = $clog2(DEPTH);
  localparam int NR = 2**D;

  src_e             rr_r;
  logic             a_grant_s;
  logic             b_grant_s;
  logic             push_s;
  logic             pop_s;
  wb_entry_t        in_entry_s;
  wb_entry_t        head_s;
  wb_entry_t        slots_s [DEPTH];
  logic [DEPTH-1:0] live_s;
  logic [AW-1:0]    rd_ptr_s;
  logic [AW:0]      count_s;
  logic             full_s;
  logic             empty_s;
  logic [NR-1:0]    pending_s;
  logic             unused_s;

  reg_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .push_entry (in_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .slots      (slots_s),
    .live       (live_s),
    .rd_ptr     (rd_ptr_s),
    .count      (count_s),
    .full       (full_s),
    .empty      (empty_s)
  );

  // Round-robin grant and selection of the accepted entry; address 0 is dropped
  always_comb begin
    a_grant_s = !full_s && a_valid && (!b_valid || rr_r == SRC_A);
    b_grant_s = !full_s && b_valid && (!a_valid || rr_r == SRC_B);
    if (a_grant_s) begin
      in_entry_s.addr = a_addr;
      in_entry_s.data = a_data;
    end else if (b_grant_s) begin
      in_entry_s.addr = b_addr;
      in_entry_s.data = b_data;
    end else begin
      in_entry_s = '0;
    end
    push_s = (a_grant_s || b_grant_s) && (|in_entry_s.addr);
  end

  assign a_ready = a_grant_s;
  assign b_ready = b_grant_s;

  // Priority pointer moves to the source that was not just granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r <= SRC_B;
    end else if (a_grant_s) begin
      rr_r <= SRC_B;
    end else if (b_grant_s) begin
      rr_r <= SRC_A;
    end else begin
      rr_r <= rr_r;
    end
  end

  // Head retirement onto the register file write port
  always_comb begin
    pop_s = !empty_s && !wr_stall;
    if (pop_s) begin
      wr_en   = 1'b1;
      wr_addr = head_s.addr;
      wr_data = head_s.data;
    end else begin
      wr_en   = 1'b0;
      wr_addr = {D{1'b0}};
      wr_data = {W{1'b0}};
    end
  end

  // Per-register pending mask over live slots; register 0 is never pending
  always_comb begin
    pending_s = {NR{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      pending_s[slots_s[i].addr] = pending_s[slots_s[i].addr] | live_s[i];
    end
    pending_s[0] = 1'b0;
  end

  assign pending = pending_s;

`ifdef REG_WB_FORWARD_EN
  // Walk oldest to youngest so the youngest matching entry wins
  function automatic logic [W-1:0] fwd_pick(
    input logic [D-1:0]     raddr,
    input logic [W-1:0]     rf,
    input wb_entry_t        s [DEPTH],
    input logic [DEPTH-1:0] lv,
    input logic [AW-1:0]    rp
  );
    logic [W-1:0]  res;
    logic [AW-1:0] idx;
    res = rf;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rp + AW'(k);
      if (lv[idx] && s[idx].addr == raddr) begin
        res = s[idx].data;
      end else begin
        res = res;
      end
    end
    if (raddr == {D{1'b0}}) begin
      res = {W{1'b0}};
    end else begin
      res = res;
    end
    return res;
  endfunction

  assign fwd_dataA = fwd_pick(rd_addrA, rf_dataA, slots_s, live_s, rd_ptr_s);
  assign fwd_dataB = fwd_pick(rd_addrB, rf_dataB, slots_s, live_s, rd_ptr_s);
  assign unused_s  = ^count_s;
`else
  assign fwd_dataA = rf_dataA;
  assign fwd_dataB = rf_dataB;
  assign unused_s  = ^{count_s, rd_addrA, rd_addrB, rd_ptr_s};
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_reg_wb_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, wr_stall;
  logic       a_ready, b_ready, wr_en;
  logic [2:0] a_addr, b_addr, wr_addr, rd_addrA, rd_addrB;
  logic [7:0] a_data, b_data, wr_data, rf_dataA, rf_dataB, fwd_dataA, fwd_dataB;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } ent_t;

  ent_t q[$];
  int   last_grant;   // 0: A granted last, 1: B granted last

  reg_wb_queue #(.W(8), .D(3), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .wr_stall  (wr_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pending   (pending),
    .rd_addrA  (rd_addrA),
    .rd_addrB  (rd_addrB),
    .rf_dataA  (rf_dataA),
    .rf_dataB  (rf_dataB),
    .fwd_dataA (fwd_dataA),
    .fwd_dataB (fwd_dataB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_fwd(input logic [2:0] a, input logic [7:0] rf);
`ifdef REG_WB_FORWARD_EN
    if (a == 3'd0) return 8'h00;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].addr == a) return q[i].data;
    end
    return rf;
`else
    return rf;
`endif
  endfunction

  // One clock: check outputs against the model, then advance model at the edge
  task automatic cycle();
    int         grant;
    bit         full;
    bit         do_pop;
    ent_t       e;
    logic [7:0] pend;
    #1;
    full  = (q.size() == DEPTH);
    grant = -1;
    if (!full) begin
      if (a_valid && b_valid) grant = (last_grant == 0) ? 1 : 0;
      else if (a_valid)       grant = 0;
      else if (b_valid)       grant = 1;
    end
    chk("a_ready", a_ready, grant == 0);
    chk("b_ready", b_ready, grant == 1);
    do_pop = (q.size() != 0) && !wr_stall;
    chk("wr_en", wr_en, do_pop);
    if (do_pop) begin
      chk("wr_addr", wr_addr, q[0].addr);
      chk("wr_data", wr_data, q[0].data);
    end else begin
      chk("wr_addr_idle", wr_addr, 3'd0);
      chk("wr_data_idle", wr_data, 8'h00);
    end
    pend = 8'h00;
    foreach (q[i]) pend[q[i].addr] = 1'b1;
    pend[0] = 1'b0;
    chk("pending", pending, pend);
    chk("fwd_dataA", fwd_dataA, ref_fwd(rd_addrA, rf_dataA));
    chk("fwd_dataB", fwd_dataB, ref_fwd(rd_addrB, rf_dataB));
    if (grant == 0) begin
      e.addr = a_addr; e.data = a_data;
    end else begin
      e.addr = b_addr; e.data = b_data;
    end
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (grant >= 0) begin
      last_grant = grant;
      if (e.addr != 3'd0) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic rand_reads();
    rd_addrA = 3'($urandom_range(0, 7));
    rd_addrB = 3'($urandom_range(0, 7));
    rf_dataA = 8'($urandom_range(0, 255));
    rf_dataB = 8'($urandom_range(0, 255));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      a_valid = 1'b0;
      b_valid = 1'b0;
      rand_reads();
      cycle();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; wr_stall = 1'b0;
    a_addr = 3'd0; b_addr = 3'd0; a_data = 8'h00; b_data = 8'h00;
    rand_reads();
    q.delete();
    last_grant = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_pending", pending, 8'h00);
    chk("rst_a_ready", a_ready, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single ALU write to r3
    a_valid = 1'b1; a_addr = 3'd3; a_data = 8'h5A; b_valid = 1'b0; rand_reads();
    #1 chk("tp1_a_ready", a_ready, 1'b1);
    cycle();
    a_valid = 1'b0;
    #1;
    chk("tp1_wr_en", wr_en, 1'b1);
    chk("tp1_wr_addr", wr_addr, 3'd3);
    chk("tp1_wr_data", wr_data, 8'h5A);
    chk("tp1_pend3", pending[3], 1'b1);
    cycle();
    #1 chk("tp1_pend_clear", pending, 8'h00);
    idle(1);

    // Contested sources alternate starting with B after reset
    do_reset();
    a_valid = 1'b1; a_addr = 3'd1; b_valid = 1'b1; b_addr = 3'd2;
    for (int k = 0; k < 4; k++) begin
      a_data = 8'(8'h10 + k); b_data = 8'(8'h20 + k); rand_reads();
      #1 chk("alt_b_ready", b_ready, (k % 2) == 0);
      cycle();
    end
    idle(2);

    // Stalled port: fifth push waits for space
    wr_stall = 1'b1;
    b_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a_valid = 1'b1; a_addr = 3'(k + 1); a_data = 8'(8'hA0 + k); rand_reads();
      #1 chk("fill_a_ready", a_ready, k < 4);
      cycle();
    end
    cycle();
    wr_stall = 1'b0;
    cycle();
    cycle();
    a_valid = 1'b0;
    idle(6);

    // Write to r0 is accepted and silently discarded
    a_valid = 1'b1; a_addr = 3'd0; a_data = 8'hFF; rand_reads();
    #1 chk("r0_a_ready", a_ready, 1'b1);
    cycle();
    a_valid = 1'b0;
    #1 chk("r0_wr_en", wr_en, 1'b0);
    idle(2);

    // Forwarding of the youngest entry for r5
    wr_stall = 1'b1;
    a_valid = 1'b1; a_addr = 3'd5; a_data = 8'h11; rand_reads();
    cycle();
    a_data = 8'h22;
    cycle();
    a_valid = 1'b0; rd_addrA = 3'd5; rf_dataA = 8'h00;
`ifdef REG_WB_FORWARD_EN
    #1 chk("fwd_r5", fwd_dataA, 8'h22);
`else
    #1 chk("fwd_r5", fwd_dataA, 8'h00);
`endif
    cycle();
    wr_stall = 1'b0;
    idle(3);

    // Asynchronous reset with three queued entries
    wr_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_valid = 1'b1; a_addr = 3'(k + 1); a_data = 8'(8'hC0 + k); rand_reads();
      cycle();
    end
    a_valid = 1'b0; wr_stall = 1'b0;
    #1 chk("mid_wr_en_before", wr_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 1'b0);
    chk("mid_rst_pending", pending, 8'h00);
    q.delete();
    last_grant = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      a_valid  = ($urandom_range(0, 9) < 6);
      b_valid  = ($urandom_range(0, 9) < 6);
      a_addr   = 3'($urandom_range(0, 7));
      b_addr   = 3'($urandom_range(0, 7));
      a_data   = 8'($urandom_range(0, 255));
      b_data   = 8'($urandom_range(0, 255));
      wr_stall = ($urandom_range(0, 9) < 3);
      rand_reads();
      if (q.size() != 0 && $urandom_range(0, 1) == 1) rd_addrA = q[q.size() - 1].addr;
      cycle();
    end
    wr_stall = 1'b0;
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
